// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/DM memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } arb_owner_t;

    // Wide enough for MEM_LAT-1 and MAX_WAIT (both at most 15).
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Requester selection for the memory port: DM wins ties unless IF has lost
// MAX_WAIT consecutive contested grants.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic if_req,
    input  logic dm_req,
    input  logic grant_en,
    output logic pick_if,
    output logic pick_dm
);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             w_force_if;

    assign w_force_if = (r_starve_cnt == CNT_W'(MAX_WAIT));
    assign pick_if    = grant_en & if_req & (~dm_req | w_force_if);
    assign pick_dm    = grant_en & dm_req & ~pick_if;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_starve_cnt <= '0;
        end else if (pick_if) begin
            r_starve_cnt <= '0;
        end else if (pick_dm && if_req && !w_force_if) begin
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, one
// transaction at a time with a fixed read latency.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int MEM_LAT  = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic [ADDR_W-1:0] mem_raddress,
    output logic [ADDR_W-1:0] mem_waddress,
    output logic [DATA_W-1:0] mem_datain,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_dataout,
    output logic              busy,
    output logic [1:0]        owner
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    arb_owner_t        r_owner;
    logic [CNT_W-1:0]  r_lat_cnt;
    logic              r_we;
    logic              r_mem_wr;
    logic              r_if_ack;
    logic              r_dm_ack;
    logic [ADDR_W-1:0] r_mem_raddress;
    logic [ADDR_W-1:0] r_mem_waddress;
    logic [DATA_W-1:0] r_mem_datain;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic              w_grant_en;
    logic              w_pick_if;
    logic              w_pick_dm;

    assign w_grant_en = (r_state == ST_IDLE);

    mem_arb_pick #(
        .MAX_WAIT (MAX_WAIT)
    ) u_pick (
        .clock    (clock),
        .reset    (reset),
        .if_req   (if_req),
        .dm_req   (dm_req),
        .grant_en (w_grant_en),
        .pick_if  (w_pick_if),
        .pick_dm  (w_pick_dm)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_pick_if || w_pick_dm) w_state_next = ST_BUSY;
            ST_BUSY: if (r_lat_cnt == '0) w_state_next = ST_RESP;
            ST_RESP: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_owner        <= OWN_NONE;
            r_lat_cnt      <= '0;
            r_we           <= 1'b0;
            r_mem_wr       <= 1'b0;
            r_if_ack       <= 1'b0;
            r_dm_ack       <= 1'b0;
            r_mem_raddress <= '0;
            r_mem_waddress <= '0;
            r_mem_datain   <= '0;
            r_if_rdata     <= '0;
            r_dm_rdata     <= '0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            r_mem_wr <= 1'b0;
            r_if_ack <= 1'b0;
            r_dm_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_if) begin
                        r_owner        <= OWN_IF;
                        r_we           <= 1'b0;
                        r_mem_raddress <= if_addr;
                        r_mem_waddress <= if_addr;
                        r_lat_cnt      <= LAT_LOAD;
                    end else if (w_pick_dm) begin
                        r_owner        <= OWN_DM;
                        r_we           <= dm_we;
                        r_mem_wr       <= dm_we;
                        r_mem_raddress <= dm_addr;
                        r_mem_waddress <= dm_addr;
                        r_mem_datain   <= dm_wdata;
                        r_lat_cnt      <= LAT_LOAD;
                    end
                end
                ST_BUSY: begin
                    if (r_lat_cnt == '0) begin
                        if (r_owner == OWN_IF) begin
                            r_if_rdata <= mem_dataout;
                            r_if_ack   <= 1'b1;
                        end else begin
                            if (!r_we) r_dm_rdata <= mem_dataout;
                            r_dm_ack <= 1'b1;
                        end
                    end else begin
                        r_lat_cnt <= r_lat_cnt - CNT_W'(1);
                    end
                end
                ST_RESP: r_owner <= OWN_NONE;
                default: r_owner <= OWN_NONE;
            endcase
        end
    end

    assign if_ack       = r_if_ack;
    assign dm_ack       = r_dm_ack;
    assign if_rdata     = r_if_rdata;
    assign dm_rdata     = r_dm_rdata;
    assign mem_raddress = r_mem_raddress;
    assign mem_waddress = r_mem_waddress;
    assign mem_datain   = r_mem_datain;
    assign mem_wr       = r_mem_wr;
    assign busy         = (r_state != ST_IDLE);
    assign owner        = r_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int LAT = 2;
    localparam int MW  = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [63:0] if_addr = '0;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [63:0] dm_addr = '0;
    logic [63:0] dm_wdata = '0;
    logic        if_ack, dm_ack, mem_wr, busy;
    logic [63:0] if_rdata, dm_rdata, mem_raddress, mem_waddress, mem_datain;
    logic [63:0] mem_dataout;
    logic [1:0]  owner;

    always #5 clock = ~clock;

    mem_port_arbiter #(
        .ADDR_W   (64),
        .DATA_W   (64),
        .MEM_LAT  (LAT),
        .MAX_WAIT (MW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_ack       (if_ack),
        .if_rdata     (if_rdata),
        .dm_req       (dm_req),
        .dm_we        (dm_we),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_ack       (dm_ack),
        .dm_rdata     (dm_rdata),
        .mem_raddress (mem_raddress),
        .mem_waddress (mem_waddress),
        .mem_datain   (mem_datain),
        .mem_wr       (mem_wr),
        .mem_dataout  (mem_dataout),
        .busy         (busy),
        .owner        (owner)
    );

    // Environment memory: data appears one edge after the address.
    logic [63:0] phys_mem [256];
    always @(posedge clock) begin
        if (mem_wr) phys_mem[mem_waddress[7:0]] <= mem_datain;
        mem_dataout <= phys_mem[mem_raddress[7:0]];
    end

    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_txn = 0;
    logic [63:0] ref_mem [256];
    bit          t_has = 0;
    int          t_g = 0;
    int          t_own = 0;
    bit          t_we = 0;
    logic [63:0] t_addr = '0;
    logic [63:0] t_wd = '0;
    int          idle_at = 0;
    int          starve = 0;
    logic [63:0] m_if_rd = '0;
    logic [63:0] m_dm_rd = '0;
    bit          rst_chk = 0;
    bit          ia_pend = 0, ia_gnt = 0, ia_ack = 0;
    bit          da_pend = 0, da_gnt = 0, da_ack = 0;
    bit          dm_hog = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [63:0] rand_addr();
        logic [7:0] lo;
        lo = 8'($urandom_range(0, 15));
        return {$urandom, 24'($urandom), lo};
    endfunction

    task automatic post_if(input logic [63:0] a);
        ia_pend = 1; ia_gnt = 0;
        if_addr = a; if_req = 1'b1;
    endtask

    task automatic post_dm(input bit we, input logic [63:0] a, input logic [63:0] d);
        da_pend = 1; da_gnt = 0;
        dm_we = we; dm_addr = a; dm_wdata = d; dm_req = 1'b1;
    endtask

    // Requester behaviour for the current cycle, based on acks seen at its start.
    task automatic upkeep(input bit rnd);
        if (!reset) begin
            ia_pend = 0; ia_gnt = 0; da_pend = 0; da_gnt = 0;
        end else begin
            if (ia_ack) begin ia_pend = 0; ia_gnt = 0; end
            if (da_ack) begin
                da_pend = 0; da_gnt = 0;
                if (dm_hog) post_dm(1'($urandom), rand_addr(), rand64());
            end
            if (ia_gnt) if_addr = rand64();
            if (da_gnt) begin
                dm_addr = rand64(); dm_wdata = rand64(); dm_we = 1'($urandom);
            end
            if (rnd) begin
                if (!ia_pend && $urandom_range(0, 2) == 0) post_if(rand_addr());
                if (!da_pend && $urandom_range(0, 2) == 0)
                    post_dm(1'($urandom), rand_addr(), rand64());
            end
        end
        if_req = ia_pend;
        dm_req = da_pend;
    endtask

    // Model decision from the inputs that the coming edge will sample.
    task automatic decide();
        bit win_if;
        if (!reset) begin
            t_has = 0; starve = 0; m_if_rd = '0; m_dm_rd = '0;
            rst_chk = 1; idle_at = cyc + 1;
        end else if (cyc >= idle_at && (if_req || dm_req)) begin
            win_if  = if_req && (!dm_req || starve == MW);
            t_has   = 1;
            t_g     = cyc;
            idle_at = cyc + LAT + 2;
            if (win_if) begin
                t_own = 1; t_we = 0; t_addr = if_addr; starve = 0; ia_gnt = 1;
            end else begin
                t_own = 2; t_we = dm_we; t_addr = dm_addr; t_wd = dm_wdata; da_gnt = 1;
                if (if_req && starve < MW) starve++;
                if (dm_we) ref_mem[dm_addr[7:0]] = dm_wdata;
            end
        end
    endtask

    task automatic tick();
        bit in_t, ack_c;
        @(posedge clock);
        #1;
        cyc++;
        ia_ack = 0; da_ack = 0;
        in_t  = t_has && cyc >= t_g + 1 && cyc <= t_g + LAT + 1;
        ack_c = t_has && cyc == t_g + LAT + 1;
        if (ack_c) begin
            if (t_own == 1) begin
                m_if_rd = ref_mem[t_addr[7:0]]; ia_ack = 1;
            end else begin
                if (!t_we) m_dm_rd = ref_mem[t_addr[7:0]];
                da_ack = 1;
            end
            n_txn++;
            $display("txn %0d cyc=%0d %s addr=%h data=%h", n_txn, cyc,
                     t_own == 1 ? "IF  " : (t_we ? "ST  " : "LD  "), t_addr,
                     t_own == 1 ? m_if_rd : (t_we ? t_wd : m_dm_rd));
        end
        chk("busy", 64'(busy), 64'(in_t));
        chk("owner", 64'(owner), 64'(in_t ? t_own : 0));
        chk("mem_wr", 64'(mem_wr), 64'(t_has && cyc == t_g + 1 && t_we));
        chk("if_ack", 64'(if_ack), 64'(ack_c && t_own == 1));
        chk("dm_ack", 64'(dm_ack), 64'(ack_c && t_own == 2));
        chk("ack_excl", 64'(if_ack & dm_ack), 64'(0));
        chk("if_rdata", if_rdata, m_if_rd);
        chk("dm_rdata", dm_rdata, m_dm_rd);
        if (in_t && !ack_c) begin
            chk("raddr", mem_raddress, t_addr);
            chk("waddr", mem_waddress, t_addr);
            if (t_we) chk("datain", mem_datain, t_wd);
        end
        if (rst_chk) begin
            chk("rst_raddr", mem_raddress, 64'(0));
            chk("rst_waddr", mem_waddress, 64'(0));
            chk("rst_datain", mem_datain, 64'(0));
            rst_chk = 0;
        end
        if (ack_c) t_has = 0;
    endtask

    task automatic step(input bit rnd);
        upkeep(rnd);
        decide();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ref_mem[i]  = rand64();
            phys_mem[i] = ref_mem[i];
        end
        ref_mem[8'h10]  = 64'h13;
        phys_mem[8'h10] = 64'h13;

        repeat (3) step(0);
        reset = 1'b1;

        // Lone fetch
        post_if(64'h10);
        repeat (6) step(0);
        chk("t1_if_rdata", if_rdata, 64'h13);

        // Store then load back
        post_dm(1'b1, 64'h40, 64'hDEAD);
        repeat (6) step(0);
        post_dm(1'b0, 64'h40, rand64());
        repeat (6) step(0);
        chk("t2_dm_rdata", dm_rdata, 64'hDEAD);

        // Simultaneous requests
        post_if(rand_addr());
        post_dm(1'b0, rand_addr(), '0);
        repeat (10) step(0);

        // Continuous data traffic against a waiting fetch
        dm_hog = 1;
        post_if(rand_addr());
        post_dm(1'b0, rand_addr(), '0);
        repeat (16) step(0);
        dm_hog = 0;
        repeat (12) step(0);

        // Reset in the middle of a fetch, then a clean refetch
        post_if(64'h10);
        step(0);
        step(0);
        reset = 1'b0;
        step(0);
        reset = 1'b1;
        chk("t5_if_rdata", if_rdata, 64'h0);
        post_if(64'h10);
        repeat (6) step(0);
        chk("t5_refetch", if_rdata, 64'h13);

        // Mixed random traffic
        repeat (400) step(1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
